add_array_stream: RTL and testbench
===================================

# add_array_stream

Parametrised two-input streaming adder actor, successor to the fixed 8-bit single-token add actor. It consumes one token from each of two input ports per firing, adds them with a selectable width, signedness and overflow mode, and queues results in an internal output FIFO. Firing no longer requires the downstream consumer to be ready in the same cycle. It sits between two token producers and one consumer on the standard DATA/SEND/ACK/COUNT/RDY actor port bundle.

## Interface
- WIDTH, 8, token width in bits for both inputs and the output (2..32)
- DEPTH, 4, output FIFO depth in tokens; power of two, 2..64
- SIGNED, 0, 1 = operands and result are two's complement
- SATURATE, 0, 1 = clamp on overflow; 0 = wrap modulo 2^WIDTH
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low reset
- Input1_DATA / Input2_DATA  in  WIDTH  operand tokens
- Input1_SEND / Input2_SEND  in  1  producer has a valid token
- Input1_COUNT / Input2_COUNT  in  16  producer token count; accepted, unused
- Input1_ACK / Input2_ACK  out  1  token consumed this cycle
- Output_DATA  out  WIDTH  head-of-FIFO result
- Output_SEND  out  1  result offered
- Output_COUNT  out  16  FIFO occupancy, zero-extended
- Output_RDY  in  1  consumer able to take tokens
- Output_ACK  in  1  consumer takes the offered token this cycle
- Overflow_COUNT  out  16  number of overflowing sums since reset

## Operation
- fire = Input1_SEND & Input2_SEND & !full. The condition is combinational.
- On fire, Input1_ACK and Input2_ACK are both high for exactly that cycle. There is never a partial ACK, and neither ACK is high without fire.
- On fire, the sum is written into the FIFO tail at the clock edge.
- Output_SEND = !empty & Output_RDY.
- Output_DATA always shows the head entry. Its value is don't-care when empty.
- A pop occurs when Output_SEND & Output_ACK. Output_ACK while Output_SEND is low is ignored.
- Arithmetic uses a (WIDTH+1)-bit sum.
  - Unsigned overflow = carry out.
  - Signed overflow = operands share a sign and the result sign differs.
- Overflow handling by mode:
  - SATURATE=0: result = low WIDTH bits.
  - SATURATE=1, unsigned: result = 2^WIDTH-1.
  - SATURATE=1, signed: result = max positive or min negative, following the operand sign.
- Overflow_COUNT increments on each fire with overflow, in either mode. It saturates at 16'hFFFF.
- Push and pop in the same cycle are both honoured and occupancy is unchanged. A full FIFO blocks fire even if a pop is occurring in the same cycle; there is no bypass.
- Output_COUNT equals the occupancy after the last edge, 0..DEPTH.

## Timing
- While RESET is low (asynchronous assertion):
  - FIFO pointers and occupancy are 0.
  - Overflow_COUNT = 0.
  - Output_SEND = 0, Input1_ACK = Input2_ACK = 0, Output_COUNT = 0, Output_DATA = 0.
- Reset deassertion takes effect at the first rising edge after RESET goes high.
- Latency: a fire in cycle N makes the result visible as Output_SEND in cycle N+1, provided Output_RDY is high.
- Throughput: one token per cycle sustained when the consumer ACKs every cycle.
- Full (occupancy = DEPTH): ACKs are held low. Input SEND/DATA must be held by the producers.
- Empty: Output_SEND is low regardless of Output_RDY.
- Pointers wrap modulo DEPTH. Occupancy uses log2(DEPTH)+1 bits.
- Reset mid-operation: queued tokens are discarded. No ACK is issued in the reset cycle.

## Structure
- Package add_array_pkg holds:
  - mode constants (ADD_WRAP, ADD_SAT; ADD_UNSIGNED, ADD_SIGNED)
  - pure function add_sat(a, b, signed, saturate), returning the result and an overflow bit
  - a clog2 helper
- Sub-module add_array_fifo: synchronous FIFO, parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Uses the same CLK and RESET.
- The top level holds the fire logic, the arithmetic, the Overflow_COUNT counter and the output gating.

## Test plan
- Reset: hold RESET low with both SENDs high. Then Output_SEND=0, ACKs=0, Output_COUNT=0, Overflow_COUNT=0. After release, the first fire occurs at the next edge.
- Unsigned wrap (WIDTH=8): 200+100 gives Output_DATA=44 one cycle later, and Overflow_COUNT=1. 3+4 gives 7 with the counter unchanged.
- Saturate: with SATURATE=1, SIGNED=1, 100+100 gives 127 and -100+-100 gives -128; Overflow_COUNT=2. With unsigned saturate, 200+100 gives 255.
- Backpressure (DEPTH=4): with Output_RDY=0, four fires complete, then ACKs drop and Output_COUNT=4. Raising RDY with ACK high drains 4 tokens in order over 4 cycles.
- Simultaneous push and pop at occupancy 2: fire and ACK in the same cycle leave Output_COUNT=2, and data order is preserved.
- Handshake integrity: with only Input1_SEND high for 10 cycles, no ACK is issued. Asserting RESET low mid-stream with 3 tokens queued gives Output_COUNT=0 immediately.

Source files
------------

// File: rtl/add_array_pkg.sv
// Shared constants and arithmetic helpers for the streaming adder actor.
package add_array_pkg;

    localparam bit ADD_WRAP     = 1'b0;
    localparam bit ADD_SAT      = 1'b1;
    localparam bit ADD_UNSIGNED = 1'b0;
    localparam bit ADD_SIGNED   = 1'b1;

    // Operands are zero-extended into this container; width selects the live bits.
    localparam int MAX_W = 32;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] sum;
    } add_res_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic add_res_t add_sat(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int               width,
        input bit               is_signed,
        input bit               saturate
    );
        logic [MAX_W:0] full_sum;
        logic [MAX_W:0] mask;
        logic           sa;
        logic           sb;
        logic           sr;
        add_res_t       res;
        mask     = (33'd1 << width) - 33'd1;
        full_sum = {1'b0, a} + {1'b0, b};
        sa       = a[width-1];
        sb       = b[width-1];
        sr       = full_sum[width-1];
        res.ovf  = is_signed ? ((sa == sb) && (sr != sa)) : full_sum[width];
        res.sum  = full_sum[MAX_W-1:0] & mask[MAX_W-1:0];
        if (res.ovf && saturate) begin
            if (!is_signed) begin
                res.sum = mask[MAX_W-1:0];
            end else if (sa) begin
                res.sum = 32'd1 << (width - 1);
            end else begin
                res.sum = mask[MAX_W-1:0] >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/add_array_stream_if.sv
// Actor port bundle: two producer ports, one consumer port and the overflow counter.
interface add_array_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Input1_DATA;
    logic             Input1_SEND;
    logic [15:0]      Input1_COUNT;
    logic             Input1_ACK;
    logic [WIDTH-1:0] Input2_DATA;
    logic             Input2_SEND;
    logic [15:0]      Input2_COUNT;
    logic             Input2_ACK;
    logic [WIDTH-1:0] Output_DATA;
    logic             Output_SEND;
    logic [15:0]      Output_COUNT;
    logic             Output_RDY;
    logic             Output_ACK;
    logic [15:0]      Overflow_COUNT;

    modport slave (
        input  Input1_DATA, Input1_SEND, Input1_COUNT,
        input  Input2_DATA, Input2_SEND, Input2_COUNT,
        input  Output_RDY, Output_ACK,
        output Input1_ACK, Input2_ACK,
        output Output_DATA, Output_SEND, Output_COUNT, Overflow_COUNT
    );

    modport master (
        output Input1_DATA, Input1_SEND, Input1_COUNT,
        output Input2_DATA, Input2_SEND, Input2_COUNT,
        output Output_RDY, Output_ACK,
        input  Input1_ACK, Input2_ACK,
        input  Output_DATA, Output_SEND, Output_COUNT, Overflow_COUNT
    );
endinterface

// File: rtl/add_array_fifo.sv
// Synchronous result FIFO; storage is not reset, only pointers and occupancy.
module add_array_fifo
    import add_array_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/add_array_stream.sv
// Two-input streaming adder actor: fires when both producers offer a token and
// the result FIFO has room; the consumer drains the FIFO independently.
module add_array_stream
    import add_array_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter bit SIGNED   = ADD_UNSIGNED,
    parameter bit SATURATE = ADD_WRAP
) (
    input  logic               CLK,
    input  logic               RESET,
    add_array_stream_if.slave  bus
);
    localparam int AW = clog2(DEPTH);

    logic             fire;
    logic             full;
    logic             empty;
    logic             pop;
    logic             out_send;
    logic [AW:0]      count;
    logic [WIDTH-1:0] head;
    add_res_t         res;
    logic [15:0]      ovf_cnt_q, ovf_cnt_d;
    logic             unused_bits;

    // RESET gates fire so no ACK escapes while reset is held.
    assign fire = bus.Input1_SEND & bus.Input2_SEND & ~full & RESET;
    assign res  = add_sat(MAX_W'(bus.Input1_DATA), MAX_W'(bus.Input2_DATA),
                          WIDTH, SIGNED, SATURATE);

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (fire && res.ovf && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    add_array_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (fire),
        .pop   (pop),
        .din   (res.sum[WIDTH-1:0]),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign out_send = ~empty & bus.Output_RDY;
    assign pop      = out_send & bus.Output_ACK;

    assign bus.Input1_ACK     = fire;
    assign bus.Input2_ACK     = fire;
    assign bus.Output_SEND    = out_send;
    assign bus.Output_DATA    = empty ? '0 : head;
    assign bus.Output_COUNT   = 16'(count);
    assign bus.Overflow_COUNT = ovf_cnt_q;

    assign unused_bits = ^{bus.Input1_COUNT, bus.Input2_COUNT, res.sum};

endmodule

// File: tb/tb_add_array_stream.sv
// Bench for add_array_stream: three arithmetic modes driven by one shared stimulus,
// compared every cycle against a queue-based reference model.
module tb_add_array_stream;

    localparam int W = 8;
    localparam int D = 4;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b0;
    logic       s1 = 1'b0, s2 = 1'b0, rdy = 1'b0, oack = 1'b0;
    logic [7:0] d1 = 8'd0, d2 = 8'd0;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    add_array_stream_if #(.WIDTH(W)) if0 ();
    add_array_stream_if #(.WIDTH(W)) if1 ();
    add_array_stream_if #(.WIDTH(W)) if2 ();

    assign {if0.Input1_DATA, if0.Input2_DATA, if0.Input1_SEND, if0.Input2_SEND,
            if0.Output_RDY, if0.Output_ACK, if0.Input1_COUNT, if0.Input2_COUNT} =
           {d1, d2, s1, s2, rdy, oack, 16'd7, 16'd9};
    assign {if1.Input1_DATA, if1.Input2_DATA, if1.Input1_SEND, if1.Input2_SEND,
            if1.Output_RDY, if1.Output_ACK, if1.Input1_COUNT, if1.Input2_COUNT} =
           {d1, d2, s1, s2, rdy, oack, 16'd7, 16'd9};
    assign {if2.Input1_DATA, if2.Input2_DATA, if2.Input1_SEND, if2.Input2_SEND,
            if2.Output_RDY, if2.Output_ACK, if2.Input1_COUNT, if2.Input2_COUNT} =
           {d1, d2, s1, s2, rdy, oack, 16'd7, 16'd9};

    // k0: unsigned wrap, k1: signed saturate, k2: unsigned saturate
    add_array_stream #(.WIDTH(W), .DEPTH(D), .SIGNED(1'b0), .SATURATE(1'b0))
        u_wrap (.CLK(CLK), .RESET(RESET), .bus(if0));
    add_array_stream #(.WIDTH(W), .DEPTH(D), .SIGNED(1'b1), .SATURATE(1'b1))
        u_ssat (.CLK(CLK), .RESET(RESET), .bus(if1));
    add_array_stream #(.WIDTH(W), .DEPTH(D), .SIGNED(1'b0), .SATURATE(1'b1))
        u_usat (.CLK(CLK), .RESET(RESET), .bus(if2));

    logic [7:0]  o_data [3];
    logic        o_send [3];
    logic        o_ack1 [3];
    logic        o_ack2 [3];
    logic [15:0] o_cnt  [3];
    logic [15:0] o_ovf  [3];

    assign o_data[0] = if0.Output_DATA;  assign o_data[1] = if1.Output_DATA;  assign o_data[2] = if2.Output_DATA;
    assign o_send[0] = if0.Output_SEND;  assign o_send[1] = if1.Output_SEND;  assign o_send[2] = if2.Output_SEND;
    assign o_ack1[0] = if0.Input1_ACK;   assign o_ack1[1] = if1.Input1_ACK;   assign o_ack1[2] = if2.Input1_ACK;
    assign o_ack2[0] = if0.Input2_ACK;   assign o_ack2[1] = if1.Input2_ACK;   assign o_ack2[2] = if2.Input2_ACK;
    assign o_cnt[0]  = if0.Output_COUNT; assign o_cnt[1]  = if1.Output_COUNT; assign o_cnt[2]  = if2.Output_COUNT;
    assign o_ovf[0]  = if0.Overflow_COUNT; assign o_ovf[1] = if1.Overflow_COUNT; assign o_ovf[2] = if2.Overflow_COUNT;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference sum from integer arithmetic: range-check the true sum.
    function automatic int ref_add(input int a, input int b, input bit sgn, input bit sat,
                                   output bit ovf);
        int av, bv, s, lo, hi;
        av  = (sgn && a > 127) ? a - 256 : a;
        bv  = (sgn && b > 127) ? b - 256 : b;
        s   = av + bv;
        lo  = sgn ? -128 : 0;
        hi  = sgn ? 127 : 255;
        ovf = (s < lo) || (s > hi);
        if (ovf && sat) return (s > hi) ? hi : lo;
        return s;
    endfunction

    typedef struct packed {
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
    } ent_t;

    ent_t q[$];
    int   ovf_u = 0;
    int   ovf_s = 0;

    always @(posedge CLK or negedge RESET) begin
        bit   f, p, ou, os, ou2;
        ent_t e;
        if (!RESET) begin
            q.delete();
            ovf_u <= 0;
            ovf_s <= 0;
        end else begin
            f = s1 && s2 && (q.size() < D);
            p = (q.size() > 0) && rdy && oack;
            if (p) void'(q.pop_front());
            if (f) begin
                e.r0 = 8'(ref_add(int'(d1), int'(d2), 1'b0, 1'b0, ou));
                e.r1 = 8'(ref_add(int'(d1), int'(d2), 1'b1, 1'b1, os));
                e.r2 = 8'(ref_add(int'(d1), int'(d2), 1'b0, 1'b1, ou2));
                q.push_back(e);
                if (ou && ovf_u < 65535) ovf_u <= ovf_u + 1;
                if (os && ovf_s < 65535) ovf_s <= ovf_s + 1;
            end
        end
    end

    always @(negedge CLK) begin
        logic       ef;
        logic [7:0] ed;
        ef = RESET && s1 && s2 && (q.size() < D);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("k%0d_ack1", k), 32'(o_ack1[k]), 32'(ef));
            chk($sformatf("k%0d_ack2", k), 32'(o_ack2[k]), 32'(ef));
            chk($sformatf("k%0d_send", k), 32'(o_send[k]), 32'((q.size() > 0) && rdy));
            chk($sformatf("k%0d_count", k), 32'(o_cnt[k]), 32'(q.size()));
            chk($sformatf("k%0d_ovf", k), 32'(o_ovf[k]), 32'((k == 1) ? ovf_s : ovf_u));
            if (q.size() > 0) begin
                ed = (k == 0) ? q[0].r0 : (k == 1) ? q[0].r1 : q[0].r2;
                chk($sformatf("k%0d_data", k), 32'(o_data[k]), 32'(ed));
            end else if (!RESET) begin
                chk($sformatf("k%0d_rst_data", k), 32'(o_data[k]), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        s1 = 1'b0; s2 = 1'b0; rdy = 1'b1; oack = 1'b1;
        repeat (D + 1) step();
    endtask

    logic [7:0] corner [5];

    initial begin
        corner[0] = 8'd0;   corner[1] = 8'd1;   corner[2] = 8'd127;
        corner[3] = 8'd128; corner[4] = 8'd255;

        // Reset held with both producers offering.
        RESET = 1'b0; s1 = 1'b1; s2 = 1'b1; rdy = 1'b1; oack = 1'b0;
        repeat (2) step();
        @(negedge CLK);
        chk("rst_ack", 32'(o_ack1[0]), 32'd0);
        chk("rst_send", 32'(o_send[0]), 32'd0);
        chk("rst_count", 32'(o_cnt[0]), 32'd0);
        chk("rst_ovf", 32'(o_ovf[0]), 32'd0);
        step();
        RESET = 1'b1; d1 = 8'd200; d2 = 8'd100;
        @(negedge CLK);
        chk("rel_ack", 32'(o_ack1[0]), 32'd1);

        // 200+100: wrap 44, signed 44 (no overflow), unsigned sat 255.
        step();
        d1 = 8'd3; d2 = 8'd4; oack = 1'b1;
        @(negedge CLK);
        chk("wrap_data", 32'(o_data[0]), 32'd44);
        chk("wrap_ovf", 32'(o_ovf[0]), 32'd1);
        chk("ssat_nochg", 32'(o_data[1]), 32'd44);
        chk("usat_data", 32'(o_data[2]), 32'd255);
        chk("latency_send", 32'(o_send[0]), 32'd1);
        step();
        s1 = 1'b0; s2 = 1'b0;
        @(negedge CLK);
        chk("small_data", 32'(o_data[0]), 32'd7);
        chk("small_ovf", 32'(o_ovf[0]), 32'd1);
        drain();

        // Signed saturation: 100+100 -> 127, -100+-100 -> -128.
        oack = 1'b0; s1 = 1'b1; s2 = 1'b1; d1 = 8'd100; d2 = 8'd100;
        step();
        d1 = 8'd156; d2 = 8'd156;
        step();
        s1 = 1'b0; s2 = 1'b0;
        @(negedge CLK);
        chk("ssat_count", 32'(o_cnt[1]), 32'd2);
        chk("ssat_pos", 32'(o_data[1]), 32'h7F);
        chk("ssat_ovf", 32'(o_ovf[1]), 32'd2);
        oack = 1'b1;
        step();
        oack = 1'b0;
        @(negedge CLK);
        chk("ssat_neg", 32'(o_data[1]), 32'h80);
        drain();

        // Backpressure: consumer not ready, four fires fill the FIFO.
        rdy = 1'b0; oack = 1'b1; s1 = 1'b1; s2 = 1'b1;
        repeat (4) begin
            d1 = 8'($urandom); d2 = 8'($urandom);
            step();
        end
        @(negedge CLK);
        chk("bp_count", 32'(o_cnt[0]), 32'd4);
        chk("bp_ack", 32'(o_ack1[0]), 32'd0);
        chk("bp_send", 32'(o_send[0]), 32'd0);
        step();
        s1 = 1'b0; s2 = 1'b0; rdy = 1'b1;
        repeat (4) step();
        @(negedge CLK);
        chk("bp_drained", 32'(o_cnt[0]), 32'd0);

        // Simultaneous push and pop at occupancy 2.
        oack = 1'b0; s1 = 1'b1; s2 = 1'b1;
        repeat (2) begin
            d1 = 8'($urandom); d2 = 8'($urandom);
            step();
        end
        oack = 1'b1; d1 = 8'($urandom); d2 = 8'($urandom);
        step();
        s1 = 1'b0; s2 = 1'b0; oack = 1'b0;
        @(negedge CLK);
        chk("pp_count", 32'(o_cnt[0]), 32'd2);
        drain();

        // Only one producer offering: never an ACK.
        s1 = 1'b1; s2 = 1'b0;
        repeat (10) step();
        @(negedge CLK);
        chk("hs_count", 32'(o_cnt[0]), 32'd0);
        s1 = 1'b0;

        // Reset with three tokens queued.
        rdy = 1'b0; s1 = 1'b1; s2 = 1'b1;
        repeat (3) begin
            d1 = 8'($urandom); d2 = 8'($urandom);
            step();
        end
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        chk("rst_mid_count", 32'(o_cnt[0]), 32'd0);
        chk("rst_mid_ack", 32'(o_ack1[0]), 32'd0);
        chk("rst_mid_ovf", 32'(o_ovf[1]), 32'd0);
        step();
        RESET = 1'b1; s1 = 1'b0; s2 = 1'b0; rdy = 1'b1;

        // Randomized traffic with occasional corner operands.
        repeat (2000) begin
            s1   = ($urandom_range(0, 3) != 0);
            s2   = ($urandom_range(0, 3) != 0);
            rdy  = ($urandom_range(0, 3) != 0);
            oack = ($urandom_range(0, 2) != 0);
            d1   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 8'($urandom);
            d2   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 8'($urandom);
            step();
        end
        drain();
        @(negedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
